// File: rtl/ISO14443A_pkg.sv
// ISO14443A shared types for the PICC receive path.
// Holds the PCD bit-sequence encoding and frame-size limits.
package ISO14443A_pkg;

   typedef enum logic [1:0] {
      PCDBitSequence_ERROR = 2'd0,
      PCDBitSequence_X     = 2'd1,
      PCDBitSequence_Y     = 2'd2,
      PCDBitSequence_Z     = 2'd3
   } PCDBitSequence;

   localparam int MAX_FRAME_BITS = 2304;

endpackage

// File: rtl/frame_parity_check.sv
// Odd-parity tracker over 9-bit groups (8 data + 1 parity).
// Built only when PCD_FRAME_PARITY_CHECK_EN is defined.
`ifdef PCD_FRAME_PARITY_CHECK_EN
module frame_parity_check (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic emit,
   input  logic data,
   output logic parity_bit,
   output logic parity_error
);

   logic [3:0] idx;
   logic       acc;

   // Group index and running XOR; outputs align with the emitted bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx          <= 4'd0;
         acc          <= 1'b0;
         parity_bit   <= 1'b0;
         parity_error <= 1'b0;
      end else begin
         parity_bit   <= 1'b0;
         parity_error <= 1'b0;
         if (clear) begin
            idx <= 4'd0;
            acc <= 1'b0;
         end else if (emit) begin
            if (idx == 4'd8) begin
               parity_bit   <= 1'b1;
               parity_error <= ~(acc ^ data);
               idx          <= 4'd0;
               acc          <= 1'b0;
            end else begin
               idx <= idx + 4'd1;
               acc <= acc ^ data;
            end
         end
      end
   end

endmodule
`endif

// File: rtl/pcd_frame_sequencer.sv
// Turns PCD bit sequences into SOC / data / EOC / error events.
// Optional parity checking: define PCD_FRAME_PARITY_CHECK_EN.
module pcd_frame_sequencer
   import ISO14443A_pkg::*;
#(
   parameter int BITS_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  PCDBitSequence     in_seq,
   input  logic              in_seq_valid,
   output logic              out_soc,
   output logic              out_eoc,
   output logic              out_data,
   output logic              out_data_valid,
   output logic              out_error,
   output logic              out_active,
   output logic [BITS_W-1:0] out_bit_count,
   output logic              out_parity_bit,
   output logic              out_parity_error
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   logic [1:0]        state, state_n;
   logic              pending, pending_n;
   logic              pend_val, pend_val_n;
   logic              prev_zero, prev_zero_n;
   logic              y_seen, y_seen_n;
   logic [BITS_W-1:0] count_n;
   logic              soc_n, eoc_n, dv_n, data_n, err_n;
   logic              emit, fault;

   // Next-state decode; a held bit is released by the following symbol.
   always_comb begin
      state_n     = state;
      pending_n   = pending;
      pend_val_n  = pend_val;
      prev_zero_n = prev_zero;
      y_seen_n    = y_seen;
      count_n     = out_bit_count;
      soc_n       = 1'b0;
      eoc_n       = 1'b0;
      dv_n        = 1'b0;
      data_n      = 1'b0;
      err_n       = 1'b0;
      emit        = 1'b0;
      fault       = 1'b0;
      if (in_seq_valid) begin
         unique case (state)
            ST_IDLE: begin
               if (in_seq == PCDBitSequence_Z) begin
                  soc_n       = 1'b1;
                  state_n     = ST_DATA;
                  prev_zero_n = 1'b1;
                  pending_n   = 1'b0;
                  count_n     = '0;
               end
            end
            ST_DATA: begin
               unique case (in_seq)
                  PCDBitSequence_X: begin
                     emit        = 1'b1;
                     pending_n   = 1'b1;
                     pend_val_n  = 1'b1;
                     prev_zero_n = 1'b0;
                  end
                  PCDBitSequence_Z: begin
                     if (prev_zero) begin
                        emit       = 1'b1;
                        pending_n  = 1'b1;
                        pend_val_n = 1'b0;
                     end else begin
                        fault = 1'b1;
                     end
                  end
                  PCDBitSequence_Y: begin
                     if (!prev_zero) begin
                        emit        = 1'b1;
                        pending_n   = 1'b1;
                        pend_val_n  = 1'b0;
                        prev_zero_n = 1'b1;
                     end else if (pending) begin
                        eoc_n     = 1'b1;
                        state_n   = ST_IDLE;
                        pending_n = 1'b0;
                     end else begin
                        fault = 1'b1;
                     end
                  end
                  default: fault = 1'b1;
               endcase
            end
            ST_ERR: begin
               if (in_seq == PCDBitSequence_Y) begin
                  if (y_seen) begin
                     state_n  = ST_IDLE;
                     y_seen_n = 1'b0;
                  end else begin
                     y_seen_n = 1'b1;
                  end
               end else begin
                  y_seen_n = 1'b0;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
      if (emit && pending) begin
         if (&out_bit_count) begin
            fault = 1'b1;
         end else begin
            dv_n    = 1'b1;
            data_n  = pend_val;
            count_n = out_bit_count + 1'b1;
         end
      end
      if (fault) begin
         err_n     = 1'b1;
         state_n   = ST_ERR;
         pending_n = 1'b0;
         y_seen_n  = 1'b0;
      end
   end

   // State, flags and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         pending        <= 1'b0;
         pend_val       <= 1'b0;
         prev_zero      <= 1'b0;
         y_seen         <= 1'b0;
         out_soc        <= 1'b0;
         out_eoc        <= 1'b0;
         out_data       <= 1'b0;
         out_data_valid <= 1'b0;
         out_error      <= 1'b0;
         out_active     <= 1'b0;
         out_bit_count  <= '0;
      end else begin
         state          <= state_n;
         pending        <= pending_n;
         pend_val       <= pend_val_n;
         prev_zero      <= prev_zero_n;
         y_seen         <= y_seen_n;
         out_soc        <= soc_n;
         out_eoc        <= eoc_n;
         out_data       <= data_n;
         out_data_valid <= dv_n;
         out_error      <= err_n;
         out_active     <= (state_n == ST_DATA);
         out_bit_count  <= count_n;
      end
   end

`ifdef PCD_FRAME_PARITY_CHECK_EN
   frame_parity_check u_parity (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (soc_n),
      .emit         (dv_n),
      .data         (data_n),
      .parity_bit   (out_parity_bit),
      .parity_error (out_parity_error)
   );
`else
   assign out_parity_bit   = 1'b0;
   assign out_parity_error = 1'b0;
`endif

endmodule
